// File: rtl/stack_mem_unit_if.sv
// Request/response channel between the Memory stage and the data-side stack/memory unit.
// Single outstanding request on a valid/ready handshake, answered by a one-cycle response pulse.
interface stack_mem_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/stack_mem_unit.sv
// Data RAM plus full-descending hardware stack for the Memory stage.
// Serves LOAD/STORE/PUSH/POP one at a time: IDLE -> ACCESS -> RESP.
module stack_mem_unit #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SP_RESET = DEPTH * 4
) (
  input  logic              clk,
  input  logic              rst,
  stack_mem_unit_if.slave   bus,
  output logic [31:0]       stack_pointer,
  output logic              stack_full,
  output logic              stack_empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t             state, stateNext;
  req_t               reqQ;
  logic [31:0]        sp, spNext;
  logic               readyQ, validQ, errQ;
  logic [DATA_W-1:0]  rdataQ;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               memWe, doRead, errNext;
  logic [IDX_W-1:0]   memWaddr, memRaddr;
  logic [IDX_W-1:0]   wordIdx, pushIdx, popIdx;
  logic               addrBad;

  assign wordIdx = reqQ.addr[IDX_W+1:2];
  assign pushIdx = IDX_W'((sp - 32'd4) >> 2);
  assign popIdx  = IDX_W'(sp >> 2);
  assign addrBad = (reqQ.addr[1:0] != 2'b00) || (reqQ.addr >= 32'(DEPTH * 4));

  // Next state plus the array/SP actions taken at the end of ACCESS
  always_comb begin
    stateNext = state;
    spNext    = sp;
    memWe     = 1'b0;
    doRead    = 1'b0;
    errNext   = 1'b0;
    memWaddr  = '0;
    memRaddr  = '0;
    case (state)
      IDLE: begin
        if (bus.req_valid) stateNext = ACCESS;
      end
      ACCESS: begin
        stateNext = RESP;
        case (reqQ.op)
          OP_LOAD: begin
            if (addrBad) errNext = 1'b1;
            else begin
              doRead   = 1'b1;
              memRaddr = wordIdx;
            end
          end
          OP_STORE: begin
            if (addrBad) errNext = 1'b1;
            else begin
              memWe    = 1'b1;
              memWaddr = wordIdx;
            end
          end
          OP_PUSH: begin
            if (sp == 32'd0) errNext = 1'b1;
            else begin
              memWe    = 1'b1;
              memWaddr = pushIdx;
              spNext   = sp - 32'd4;
            end
          end
          default: begin
            if (sp == 32'(SP_RESET)) errNext = 1'b1;
            else begin
              doRead   = 1'b1;
              memRaddr = popIdx;
              spNext   = sp + 32'd4;
            end
          end
        endcase
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Async reset lands the FSM in IDLE, which by itself blocks any pending write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      readyQ <= 1'b1;
      validQ <= 1'b0;
      rdataQ <= '0;
      errQ   <= 1'b0;
      sp     <= 32'(SP_RESET);
      reqQ   <= '0;
    end else begin
      state  <= stateNext;
      readyQ <= (stateNext == IDLE);
      validQ <= (stateNext == RESP);
      sp     <= spNext;
      if (state == IDLE && bus.req_valid) begin
        reqQ <= '{op: bus.req_op, addr: bus.req_addr, wdata: bus.req_wdata};
      end
      if (state == ACCESS) begin
        rdataQ <= doRead ? mem[memRaddr] : '0;
        errQ   <= errNext;
      end
    end
  end

  // Array contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (memWe) mem[memWaddr] <= reqQ.wdata;
  end

  assign bus.req_ready = readyQ;
  assign bus.rsp_valid = validQ;
  assign bus.rsp_rdata = rdataQ;
  assign bus.rsp_err   = errQ;
  assign stack_pointer = sp;
  assign stack_full    = (sp == 32'd0);
  assign stack_empty   = (sp == 32'(SP_RESET));

endmodule
